// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift register.
//   op_e    : 3-bit operation code presented on the Op port.
//   state_e : control FSM states (IDLE accepts requests, SHIFT steps, DONE pulses).
package shift_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_SLL   = 3'b001,
    OP_SRL   = 3'b010,
    OP_SRA   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_CLEAR = 3'b110,
    OP_NOP   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the shift register.
//   q_i       : current register contents
//   op_i      : operation code (only shift/rotate codes change q_o)
//   serial_in : fill bit for logical shifts
//   q_o       : register contents after one 1-bit step
//   bit_out   : the bit that leaves the register on this step
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_o,
  output logic             bit_out
);

  // NOTE: every output gets a default before the case so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    q_o     = q_i;
    bit_out = 1'b0;
    case (op_e'(op_i))
      OP_SLL: begin
        q_o     = {q_i[WIDTH-2:0], serial_in};
        bit_out = q_i[WIDTH-1];
      end
      OP_SRL: begin
        q_o     = {serial_in, q_i[WIDTH-1:1]};
        bit_out = q_i[0];
      end
      OP_SRA: begin
        q_o     = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        bit_out = q_i[0];
      end
      OP_ROL: begin
        q_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        bit_out = q_i[WIDTH-1];
      end
      OP_ROR: begin
        q_o     = {q_i[0], q_i[WIDTH-1:1]};
        bit_out = q_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shift_reg.sv
// Sequential shift register: parallel load/clear, and multi-bit shifts or
// rotates carried out one bit per clock.
//   Clk        : clock, rising edge
//   Reset      : asynchronous active-low reset
//   Start      : request, sampled only in IDLE
//   Op         : operation code (see shift_pkg::op_e)
//   Load_data  : parallel load value
//   Shamt      : shift amount in bits
//   Serial_in  : fill bit for SLL/SRL
//   Q          : register contents
//   Busy       : high while shifting
//   Done       : one-cycle completion pulse
//   Serial_out : last bit shifted out
module seq_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [2:0]               Op,
  input  logic [WIDTH-1:0]         Load_data,
  input  logic [$clog2(WIDTH)-1:0] Shamt,
  input  logic                     Serial_in,
  output logic [WIDTH-1:0]         Q,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Serial_out
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q,    op_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             so_q,    so_d;

  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  // Step logic works from the latched op so mid-operation Op changes are inert.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i       (q_q),
    .op_i      (op_q),
    .serial_in (Serial_in),
    .q_o       (step_q),
    .bit_out   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    so_d    = so_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_DONE;
          case (op_e'(Op))
            OP_LOAD:  q_d = Load_data;
            OP_CLEAR: q_d = '0;
            OP_NOP:   ;
            default: begin
              // Zero-length shifts complete immediately without entering SHIFT.
              if (Shamt != '0) begin
                op_d    = op_e'(Op);
                cnt_d   = Shamt;
                state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        q_d   = step_q;
        so_d  = step_bit;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      so_q    <= so_d;
    end
  end

  // Status outputs decode the state register directly, so reset clears them
  // without waiting for a clock edge.
  assign Q          = q_q;
  assign Busy       = (state_q == ST_SHIFT);
  assign Done       = (state_q == ST_DONE);
  assign Serial_out = so_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
module tb_seq_shift_reg;
  import shift_pkg::*;

  localparam logic [7:0] RST_VAL = 8'h96;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [2:0] Op;
  logic [7:0] Load_data;
  logic [2:0] Shamt;
  logic       Serial_in;
  logic [7:0] Q;
  logic       Busy;
  logic       Done;
  logic       Serial_out;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_reg #(.WIDTH(8), .RESET_VAL(RST_VAL)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .Load_data  (Load_data),
    .Shamt      (Shamt),
    .Serial_in  (Serial_in),
    .Q          (Q),
    .Busy       (Busy),
    .Done       (Done),
    .Serial_out (Serial_out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [2:0] shamt;
    logic [7:0] pre;
    logic [7:0] ld;
    logic       si;
    logic [7:0] exp_q;
    int         exp_busy;
    logic       chk_so;
    logic       exp_so;
  } vec_t;

  function automatic vec_t mk(string name, op_e op, logic [2:0] shamt, logic [7:0] pre,
                              logic [7:0] ld, logic si, logic [7:0] exp_q, int exp_busy,
                              logic chk_so, logic exp_so);
    vec_t v;
    v.name = name; v.op = op; v.shamt = shamt; v.pre = pre; v.ld = ld; v.si = si;
    v.exp_q = exp_q; v.exp_busy = exp_busy; v.chk_so = chk_so; v.exp_so = exp_so;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Parallel load through the normal request path; ends back in IDLE.
  task automatic load_val(input logic [7:0] d);
    Op = OP_LOAD; Load_data = d; Shamt = 3'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
  endtask

  // Issue one request and follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [2:0] shamt, input logic [7:0] ld,
                        input logic si, output int busy_cnt, output logic [7:0] q_first,
                        output logic [7:0] q_done, output logic so_done,
                        output bit done_seen, output bit idle_after);
    Op = op; Shamt = shamt; Load_data = ld; Serial_in = si; Start = 1'b1;
    tick();
    Start = 1'b0;
    q_first   = Q;
    q_done    = 8'h00;
    so_done   = 1'b0;
    busy_cnt  = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_seen = 1'b1;
        q_done    = Q;
        so_done   = Serial_out;
      end else begin
        tick();
      end
    end
    tick();
    idle_after = !Busy && !Done;
  endtask

  vec_t       vecs[12];
  int         busy_cnt;
  logic [7:0] q_first, q_done;
  logic       so_done;
  bit         done_seen, idle_after;
  int         b;
  bit         seen;

  initial begin
    vecs[0]  = mk("sra_a5_3",   OP_SRA,   3'd3, 8'hA5, 8'h00, 1'b0, 8'hF4, 3, 1'b1, 1'b1);
    vecs[1]  = mk("rol_3c_4",   OP_ROL,   3'd4, 8'h3C, 8'h00, 1'b0, 8'hC3, 4, 1'b1, 1'b1);
    vecs[2]  = mk("sll_01_7",   OP_SLL,   3'd7, 8'h01, 8'h00, 1'b1, 8'hFF, 7, 1'b1, 1'b0);
    vecs[3]  = mk("srl_81_1",   OP_SRL,   3'd1, 8'h81, 8'h00, 1'b0, 8'h40, 1, 1'b1, 1'b1);
    vecs[4]  = mk("ror_01_1",   OP_ROR,   3'd1, 8'h01, 8'h00, 1'b0, 8'h80, 1, 1'b1, 1'b1);
    vecs[5]  = mk("srl_96_0",   OP_SRL,   3'd0, 8'h96, 8'h00, 1'b1, 8'h96, 0, 1'b0, 1'b0);
    vecs[6]  = mk("clear_ff",   OP_CLEAR, 3'd3, 8'hFF, 8'h12, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    vecs[7]  = mk("nop_5a",     OP_NOP,   3'd4, 8'h5A, 8'h33, 1'b1, 8'h5A, 0, 1'b0, 1'b0);
    vecs[8]  = mk("load_c7",    OP_LOAD,  3'd5, 8'h00, 8'hC7, 1'b0, 8'hC7, 0, 1'b0, 1'b0);
    vecs[9]  = mk("sra_7f_7",   OP_SRA,   3'd7, 8'h7F, 8'h00, 1'b1, 8'h00, 7, 1'b1, 1'b1);
    vecs[10] = mk("sll_ff_1",   OP_SLL,   3'd1, 8'hFF, 8'h00, 1'b0, 8'hFE, 1, 1'b1, 1'b1);
    vecs[11] = mk("srl_00_2si", OP_SRL,   3'd2, 8'h00, 8'h00, 1'b1, 8'hC0, 2, 1'b1, 1'b0);

    Reset = 1'b0; Start = 1'b0; Op = OP_NOP; Load_data = 8'h00; Shamt = 3'd0; Serial_in = 1'b0;

    // Reset state, observed while reset is still asserted.
    #12;
    check("rst_q",    Q,          RST_VAL);
    check("rst_busy", Busy,       1'b0);
    check("rst_done", Done,       1'b0);
    check("rst_so",   Serial_out, 1'b0);
    @(posedge Clk);
    #3 Reset = 1'b1;

    // Table-driven operations, each from a freshly loaded value.
    foreach (vecs[i]) begin
      load_val(vecs[i].pre);
      run_op(vecs[i].op, vecs[i].shamt, vecs[i].ld, vecs[i].si,
             busy_cnt, q_first, q_done, so_done, done_seen, idle_after);
      check({vecs[i].name, " done_seen"},  done_seen, 1'b1);
      check({vecs[i].name, " busy_cyc"},   busy_cnt,  vecs[i].exp_busy);
      check({vecs[i].name, " q_at_done"},  q_done,    vecs[i].exp_q);
      check({vecs[i].name, " q_after_st"}, q_first,
            (vecs[i].exp_busy > 0) ? vecs[i].pre : vecs[i].exp_q);
      check({vecs[i].name, " idle_after"}, idle_after, 1'b1);
      if (vecs[i].chk_so) check({vecs[i].name, " so"}, so_done, vecs[i].exp_so);
    end

    // Start pulsed mid-shift (with a different Op) must be ignored.
    load_val(8'h0F);
    Op = OP_SLL; Shamt = 3'd5; Serial_in = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    b = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (Busy) b++;
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (b == 2) begin
        Start = 1'b1; Op = OP_CLEAR; Shamt = 3'd1; Load_data = 8'h00;
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    Start = 1'b0;
    check("ign_done_seen", seen,       1'b1);
    check("ign_busy_cyc",  b,          5);
    check("ign_q",         Q,          8'hE0);
    check("ign_so",        Serial_out, 1'b1);
    tick();
    check("ign_q_after",   Q,          8'hE0);
    check("ign_idle",      {Busy, Done}, 2'b00);

    // Start held high: ignored in DONE, accepted again on the following edge.
    Op = OP_LOAD; Load_data = 8'h11; Start = 1'b1;
    tick();
    check("hold_q1",    Q,    8'h11);
    check("hold_done1", Done, 1'b1);
    Load_data = 8'h22;
    tick();
    check("hold_q_idle",    Q,    8'h11);
    check("hold_done_idle", Done, 1'b0);
    tick();
    check("hold_q2",    Q,    8'h22);
    check("hold_done2", Done, 1'b1);
    Start = 1'b0;
    tick();

    // Asynchronous reset in the middle of a shift.
    load_val(8'hFF);
    Op = OP_ROR; Shamt = 3'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    check("mid_busy_pre", Busy,       1'b1);
    check("mid_so_pre",   Serial_out, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_q",    Q,          RST_VAL);
    check("mid_rst_busy", Busy,       1'b0);
    check("mid_rst_done", Done,       1'b0);
    check("mid_rst_so",   Serial_out, 1'b0);
    #2 Reset = 1'b1;
    Op = OP_LOAD; Load_data = 8'h5A; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("post_rst_q",    Q,    8'h5A);
    check("post_rst_done", Done, 1'b1);
    check("post_rst_busy", Busy, 1'b0);
    tick();
    check("post_rst_idle", Done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
